neo_bus_arbiter: RTL and testbench
==================================

NEO_BUS_ARBITER -- requirements
Module: neo_bus_arbiter

Interface
REQ-001 Parameter COOLDOWN, default 8: minimum CLK_24M cycles the CPU keeps the bus after any release.
REQ-002 Parameter MAX_HOLD, default 4096: cycles an external master may hold the bus before forced release (watchdog build only).
REQ-003 Parameter IDLE_SAMPLES, default 2: consecutive cycles with nAS high required before bus takeover.
REQ-004 CLK_24M  input  1  clock; all logic on posedge.
REQ-005 nRESET  input  1  reset, asynchronous, active-low.
REQ-006 REQ  input  1  external master (loader/DMA) bus request, level.
REQ-007 GNT  output  1  external master owns the 68k bus, level.
REQ-008 nBR  output  1  bus request to 68k, active-low.
REQ-009 nBGACK  output  1  bus grant acknowledge to 68k, active-low.
REQ-010 nBG  input  1  bus grant from 68k, active-low, same clock domain.
REQ-011 nAS  input  1  68k address strobe, active-low, same clock domain.
REQ-012 TIMEOUT  output  1  one-cycle pulse on watchdog forced release.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, REQUEST, WAIT_IDLE, OWN, RELEASE, COOLDOWN; all outputs registered.
REQ-015 IDLE: nBR=1, nBGACK=1, GNT=0; REQ=1 -> REQUEST next cycle.
REQ-016 REQUEST: nBR=0; nBG=0 -> WAIT_IDLE; REQ=0 before nBG=0 -> IDLE with nBR=1 (abort).
REQ-017 WAIT_IDLE: nBR=0; an idle counter SHALL count consecutive cycles with nAS=1, clearing on nAS=0; on reaching IDLE_SAMPLES -> OWN; REQ=0 -> IDLE (abort, nBGACK never asserted).
REQ-018 OWN: nBGACK=0, nBR=1, GNT=1 from the first OWN cycle; GNT SHALL never be 1 unless nBGACK=0 in the same cycle.
REQ-019 OWN exits to RELEASE when REQ=0, or on watchdog expiry (REQ-027).
REQ-020 RELEASE: lasts exactly one cycle; GNT=0 and nBGACK=0, giving the master one cycle to tristate; then -> COOLDOWN.
REQ-021 COOLDOWN: nBGACK=1, nBR=1; a counter SHALL hold the state exactly COOLDOWN cycles regardless of REQ, then -> IDLE.
REQ-022 REQ held high through COOLDOWN SHALL cause IDLE -> REQUEST on the cycle after COOLDOWN ends.
REQ-023 Latency: REQ rising in IDLE with nBG returned the cycle after nBR falls and nAS already high SHALL give GNT=1 within 3+IDLE_SAMPLES cycles.
REQ-024 Counters SHALL saturate, never wrap; widths are sized from the parameters using clog2.

Reset
REQ-025 nRESET low SHALL immediately force IDLE, nBR=1, nBGACK=1, GNT=0, TIMEOUT=0, BUSY=0, all counters zero, including mid-OWN.
REQ-026 After nRESET rises the FSM SHALL stay in IDLE for at least one cycle before honouring REQ.

Configuration
REQ-027 With macro NEO_BUS_ARB_WATCHDOG_EN defined, a hold counter SHALL clear on OWN entry, count each OWN cycle, and at MAX_HOLD force OWN -> RELEASE with TIMEOUT=1 for that cycle; after a forced release, REQ SHALL be low for at least one cycle before a new REQUEST.
REQ-028 Without NEO_BUS_ARB_WATCHDOG_EN, the hold counter SHALL be absent, TIMEOUT tied 0, and OWN lasts until REQ=0.

Verification
REQ-029 REQ=1, nBG falls 2 cycles after nBR=0, nAS=1 -> nBGACK=0 and GNT=1 after 2 idle samples, nBR=1 same cycle.
REQ-030 nAS=0 for 5 cycles after nBG=0 -> nBGACK stays 1 until 2 cycles after nAS rises.
REQ-031 REQ dropped in REQUEST before nBG -> nBR=1 next cycle, GNT never 1, state IDLE.
REQ-032 REQ falls in OWN -> one RELEASE cycle (GNT=0, nBGACK=0), then nBGACK=1 for 8 cycles with REQ held 1, then nBR=0.
REQ-033 Watchdog build, MAX_HOLD=16, REQ held 1 -> TIMEOUT pulse after 16 OWN cycles, release, no re-request until REQ toggles low.
REQ-034 nRESET asserted mid-OWN -> nBGACK=1, GNT=0, nBR=1 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/neo_bus_arbiter.sv
// neo_bus_arbiter: hands the 68k bus to an external master (loader/DMA).
// Sequence: request bus (nBR), wait for grant (nBG), wait for the bus to go
// idle (nAS high for IDLE_SAMPLES cycles), own it (nBGACK/GNT), give the master
// one cycle to tristate, then hold the CPU on the bus for COOLDOWN cycles.
// Optional watchdog: define NEO_BUS_ARB_WATCHDOG_EN to force release after
// MAX_HOLD owned cycles (TIMEOUT pulse, REQ must drop before re-request).
`timescale 1ns/1ps
module neo_bus_arbiter #(
  parameter int unsigned COOLDOWN     = 8,
  parameter int unsigned MAX_HOLD     = 4096,
  parameter int unsigned IDLE_SAMPLES = 2
) (
  input  logic CLK_24M,
  input  logic nRESET,
  input  logic REQ,
  output logic GNT,
  output logic nBR,
  output logic nBGACK,
  input  logic nBG,
  input  logic nAS,
  output logic TIMEOUT,
  output logic BUSY
);

  // Counters only ever need to reach PARAM-1: the state moves on instead of
  // incrementing past that value, which also makes them saturate.
  localparam int unsigned IW = (IDLE_SAMPLES > 1) ? $clog2(IDLE_SAMPLES) : 1;
  localparam int unsigned CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SAMPLES - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN - 1);

  if (COOLDOWN < 1 || IDLE_SAMPLES < 1 || MAX_HOLD < 1) begin : g_bad_params
    $error("neo_bus_arbiter: COOLDOWN, IDLE_SAMPLES and MAX_HOLD must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_IDLE,
    ST_OWN,
    ST_RELEASE,
    ST_COOLDOWN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] cd_cnt_q, cd_cnt_d;
  logic          settled_q;
  logic          gnt_q, nbr_q, nbgack_q, busy_q;
  logic          req_ok;

`ifdef NEO_BUS_ARB_WATCHDOG_EN
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          need_low_q, need_low_d;
  logic          timeout_q, timeout_d;

  assign req_ok  = REQ & settled_q & ~need_low_q;
  assign TIMEOUT = timeout_q;
`else
  assign req_ok  = REQ & settled_q;
  assign TIMEOUT = 1'b0;
`endif

  assign GNT    = gnt_q;
  assign nBR    = nbr_q;
  assign nBGACK = nbgack_q;
  assign BUSY   = busy_q;

  // Next-state and counter logic; counters clear whenever their state is left.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    cd_cnt_d   = '0;
`ifdef NEO_BUS_ARB_WATCHDOG_EN
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
    need_low_d = need_low_q & REQ;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_ok) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (!REQ)      state_d = ST_IDLE;
        else if (!nBG) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!REQ) begin
          state_d = ST_IDLE;
        end else if (nAS) begin
          if (idle_cnt_q >= IDLE_LAST) state_d    = ST_OWN;
          else                         idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_OWN: begin
        if (!REQ) begin
          state_d = ST_RELEASE;
        end
`ifdef NEO_BUS_ARB_WATCHDOG_EN
        else if (hold_cnt_q >= HOLD_LAST) begin
          state_d    = ST_RELEASE;
          timeout_d  = 1'b1;
          need_low_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q >= CD_LAST) state_d  = ST_IDLE;
        else                     cd_cnt_d = cd_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      cd_cnt_q   <= '0;
      settled_q  <= 1'b0;
      gnt_q      <= 1'b0;
      nbr_q      <= 1'b1;
      nbgack_q   <= 1'b1;
      busy_q     <= 1'b0;
`ifdef NEO_BUS_ARB_WATCHDOG_EN
      hold_cnt_q <= '0;
      need_low_q <= 1'b0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      settled_q  <= 1'b1;
      gnt_q      <= (state_d == ST_OWN);
      nbr_q      <= !((state_d == ST_REQUEST) || (state_d == ST_WAIT_IDLE));
      nbgack_q   <= !((state_d == ST_OWN) || (state_d == ST_RELEASE));
      busy_q     <= (state_d != ST_IDLE);
`ifdef NEO_BUS_ARB_WATCHDOG_EN
      hold_cnt_q <= hold_cnt_d;
      need_low_q <= need_low_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_neo_bus_arbiter.sv
// Testbench for neo_bus_arbiter: a phase-level reference model advanced every
// clock, compared against the DUT on every falling edge, plus directed
// sequences with hand-computed literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_neo_bus_arbiter;

  localparam int COOLDOWN     = 8;
  localparam int MAX_HOLD     = 16;
  localparam int IDLE_SAMPLES = 2;
`ifdef NEO_BUS_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic CLK_24M = 1'b0;
  logic nRESET  = 1'b0;
  logic REQ     = 1'b0;
  logic nBG     = 1'b1;
  logic nAS     = 1'b1;
  logic GNT, nBR, nBGACK, TIMEOUT, BUSY;

  int checks = 0;
  int errors = 0;
  bit running = 1'b0;

  neo_bus_arbiter #(
    .COOLDOWN    (COOLDOWN),
    .MAX_HOLD    (MAX_HOLD),
    .IDLE_SAMPLES(IDLE_SAMPLES)
  ) dut (
    .CLK_24M(CLK_24M),
    .nRESET (nRESET),
    .REQ    (REQ),
    .GNT    (GNT),
    .nBR    (nBR),
    .nBGACK (nBGACK),
    .nBG    (nBG),
    .nAS    (nAS),
    .TIMEOUT(TIMEOUT),
    .BUSY   (BUSY)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the handover plus plain event counts.
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_OWN = 3, P_REL = 4, P_COOL = 5;
  int m_phase = P_IDLE;
  int m_run = 0, m_left = 0, m_owned = 0;
  bit m_fresh = 1'b1, m_block = 1'b0, m_to = 1'b0;

  always @(posedge CLK_24M) begin
    if (!nRESET) begin
      m_phase = P_IDLE; m_run = 0; m_left = 0; m_owned = 0;
      m_fresh = 1'b1; m_block = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      case (m_phase)
        P_IDLE: if (REQ && !m_fresh && !(WD && m_block)) m_phase = P_REQ;
        P_REQ: begin
          if (!REQ) m_phase = P_IDLE;
          else if (!nBG) begin m_phase = P_WAIT; m_run = 0; end
        end
        P_WAIT: begin
          if (!REQ) m_phase = P_IDLE;
          else if (nAS) begin
            m_run++;
            if (m_run >= IDLE_SAMPLES) begin m_phase = P_OWN; m_owned = 0; end
          end else m_run = 0;
        end
        P_OWN: begin
          m_owned++;
          if (!REQ) m_phase = P_REL;
          else if (WD && m_owned >= MAX_HOLD) begin
            m_phase = P_REL; m_to = 1'b1; m_block = 1'b1;
          end
        end
        P_REL: begin m_phase = P_COOL; m_left = COOLDOWN; end
        P_COOL: begin
          m_left--;
          if (m_left == 0) m_phase = P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
      if (!REQ) m_block = 1'b0;
      m_fresh = 1'b0;
    end
  end

  // Compare process: every falling edge, DUT vs model (reset values while nRESET low).
  always @(negedge CLK_24M) begin
    if (running) begin
      if (!nRESET) begin
        chk("m_nbr", nBR, 1'b1);
        chk("m_nbgack", nBGACK, 1'b1);
        chk("m_gnt", GNT, 1'b0);
        chk("m_busy", BUSY, 1'b0);
        chk("m_timeout", TIMEOUT, 1'b0);
      end else begin
        chk("m_nbr", nBR, !(m_phase == P_REQ || m_phase == P_WAIT));
        chk("m_nbgack", nBGACK, !(m_phase == P_OWN || m_phase == P_REL));
        chk("m_gnt", GNT, m_phase == P_OWN);
        chk("m_busy", BUSY, m_phase != P_IDLE);
        chk("m_timeout", TIMEOUT, m_to);
      end
      chk("gnt_without_bgack", GNT & nBGACK, 1'b0);
    end
  end

  task automatic step();
    @(posedge CLK_24M);
    #2;
  endtask

  int own_cnt, to_cnt;
  bit seen_to;

  initial begin
    running = 1'b1;
    repeat (3) step();
    chk("rst_nbr", nBR, 1'b1);
    chk("rst_nbgack", nBGACK, 1'b1);
    chk("rst_gnt", GNT, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_timeout", TIMEOUT, 1'b0);
    nRESET = 1'b1;
    step();

    // Grant after two idle samples, nBG returned two cycles after nBR falls.
    REQ = 1'b1;
    step();
    chk("req_nbr_low", nBR, 1'b0);
    chk("req_gnt_low", GNT, 1'b0);
    step();
    nBG = 1'b0;
    step();
    chk("wait_nbgack", nBGACK, 1'b1);
    step();
    chk("wait2_gnt", GNT, 1'b0);
    step();
    chk("own_gnt", GNT, 1'b1);
    chk("own_nbgack", nBGACK, 1'b0);
    chk("own_nbr", nBR, 1'b1);

    // Release: one tristate cycle, then cooldown with REQ held high.
    REQ = 1'b0;
    step();
    chk("rel_gnt", GNT, 1'b0);
    chk("rel_nbgack", nBGACK, 1'b0);
    REQ = 1'b1;
    nBG = 1'b1;
    for (int i = 0; i < COOLDOWN; i++) begin
      step();
      chk("cool_nbgack", nBGACK, 1'b1);
      chk("cool_nbr", nBR, 1'b1);
      chk("cool_busy", BUSY, 1'b1);
    end
    step();
    chk("post_cool_idle", BUSY, 1'b0);
    step();
    chk("rerequest_nbr", nBR, 1'b0);

    // Abort in REQUEST before nBG.
    REQ = 1'b0;
    step();
    chk("abort_nbr", nBR, 1'b1);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_gnt", GNT, 1'b0);

    // Bus busy (nAS low) for 5 cycles after grant.
    nBG = 1'b0; nAS = 1'b0; REQ = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("as_busy_nbgack", nBGACK, 1'b1);
    end
    nAS = 1'b1;
    step();
    chk("as_first_idle_nbgack", nBGACK, 1'b1);
    step();
    chk("as_own_nbgack", nBGACK, 1'b0);

    // Asynchronous reset mid-OWN, then one settle cycle before REQ is honoured.
    #1;
    nRESET = 1'b0;
    #1;
    chk("async_nbgack", nBGACK, 1'b1);
    chk("async_gnt", GNT, 1'b0);
    chk("async_nbr", nBR, 1'b1);
    chk("async_busy", BUSY, 1'b0);
    nBG = 1'b1;
    step();
    nRESET = 1'b1;
    step();
    chk("settle_busy", BUSY, 1'b0);
    step();
    chk("settle_then_req", nBR, 1'b0);
    REQ = 1'b0;
    repeat (3) step();

    if (WD) begin
      // Forced release after MAX_HOLD owned cycles, no re-request while REQ high.
      own_cnt = 0; to_cnt = 0; seen_to = 1'b0;
      REQ = 1'b1; nBG = 1'b0; nAS = 1'b1;
      for (int i = 0; i < 60; i++) begin
        step();
        if (nBR) nBG = 1'b1;
        if (GNT) own_cnt++;
        if (TIMEOUT) begin to_cnt++; seen_to = 1'b1; end
      end
      chk("wd_own_len_16", (own_cnt == MAX_HOLD), 1'b1);
      chk("wd_one_timeout", (to_cnt == 1), 1'b1);
      chk("wd_no_rereq", nBR, 1'b1);
      REQ = 1'b0;
      step();
      REQ = 1'b1;
      step();
      chk("wd_rereq_after_toggle", nBR, 1'b0);
      REQ = 1'b0;
      repeat (3) step();
    end

    // Randomized traffic with a 68k-like responder.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(11) == 0) REQ = ~REQ;
      nAS = ($urandom_range(3) != 0);
      if (nBR) nBG = 1'b1;
      else if ($urandom_range(2) == 0) nBG = 1'b0;
      if (c == 1500) nRESET = 1'b0;
      if (c == 1502) nRESET = 1'b1;
      step();
    end

    running = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
